// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg : shared types and helpers for the handshaked sequential ALU.
//   alu_op_t    - 4-bit opcode encoding driven on ALUControl
//   alu_state_t - control FSM states (IDLE / BUSY / DONE)
//   alu_flags_t - packed NZCV flag bundle
//   ALU_UNDEF   - fill bit replicated across the result for unknown opcodes
//   alu_flags_f - flag builder used by both the single-cycle and MUL paths
// ---------------------------------------------------------------------------
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_OR   = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_XOR  = 4'b0011,
      ALU_LSL  = 4'b0100,
      ALU_LSR  = 4'b0101,
      ALU_SUB  = 4'b0110,
      ALU_PASS = 4'b0111,
      ALU_MUL  = 4'b1000
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } alu_state_t;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } alu_flags_t;

   // Undefined opcodes produce a result of all ALU_UNDEF bits.
   localparam logic ALU_UNDEF = 1'b1;

   // N and Z come from the final result; C and V are supplied by the caller
   // (only ADD/SUB produce non-zero C/V).
   function automatic alu_flags_t alu_flags_f(input logic res_msb,
                                              input logic res_is_zero,
                                              input logic c,
                                              input logic v);
      alu_flags_t f;
      f.n = res_msb;
      f.z = res_is_zero;
      f.c = c;
      f.v = v;
      return f;
   endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// ---------------------------------------------------------------------------
// alu_mul_iter : iterative shift-add multiplier, low WIDTH bits of a*b.
//   Retires MUL_STEP multiplier bits per cycle; WIDTH/MUL_STEP cycles per op.
// Ports:
//   clk       in  clock, rising edge
//   reset     in  asynchronous active-low reset
//   start_i   in  latch a_i/b_i and clear the accumulator
//   a_i, b_i  in  operands (sampled only on start_i)
//   done_o    out high during the cycle that retires the final step
//   product_o out product, valid while done_o is high
// ---------------------------------------------------------------------------
module alu_mul_iter
   import alu_pkg::*;
#(
   parameter int WIDTH    = 64,
   parameter int MUL_STEP = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] product_o
);

   localparam int STEPS = WIDTH / MUL_STEP;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

   logic             busy_q, busy_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] partial;
   logic             last;

   // Sum of the shifted multiplicands selected by the low MUL_STEP bits.
   always_comb begin
      partial = '0;
      for (int j = 0; j < MUL_STEP; j++) begin
         if (mplier_q[j]) partial = partial + (mcand_q << j);
      end
   end

   assign last      = busy_q && (cnt_q == CW'(STEPS - 1));
   assign done_o    = last;
   // Final step is handed out combinationally so the caller can register it
   // in the same cycle it is retired.
   assign product_o = acc_q + partial;

   always_comb begin
      busy_d   = busy_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      if (start_i) begin
         busy_d   = 1'b1;
         cnt_d    = '0;
         mcand_d  = a_i;
         mplier_d = b_i;
         acc_d    = '0;
      end else if (busy_q) begin
         acc_d    = acc_q + partial;
         mcand_d  = mcand_q << MUL_STEP;
         mplier_d = mplier_q >> MUL_STEP;
         cnt_d    = cnt_q + CW'(1);
         if (last) busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q   <= 1'b0;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else begin
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq : handshaked ALU with registered result and NZCV flags.
//   Build option: define ALU_SEQ_MUL_EN to enable the iterative MUL opcode
//   (alu_mul_iter); otherwise opcode 1000 behaves as an undefined opcode.
// Ports:
//   clk        in  clock, rising edge
//   reset      in  asynchronous active-low reset
//   in_valid   in  request valid          in_ready  out  request accepted when high
//   a, b       in  operands               ALUControl in  opcode (alu_op_t)
//   out_valid  out result valid           out_ready in   consumer takes result
//   result     out registered result
//   zero/negative/carry/overflow out  registered Z/N/C/V flags
// ---------------------------------------------------------------------------
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH    = 64,
   parameter int MUL_STEP = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       ALUControl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             negative,
   output logic             carry,
   output logic             overflow
);

   localparam int SH = $clog2(WIDTH);

   alu_state_t       state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   alu_flags_t       flags_q, flags_d;

   logic [WIDTH-1:0] alu_res;
   logic [WIDTH:0]   sum;
   logic             alu_c, alu_v;
   alu_flags_t       alu_flags;

   // Single-cycle datapath
   always_comb begin
      alu_res = '0;
      sum     = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (ALUControl)
         ALU_AND:  alu_res = a & b;
         ALU_OR:   alu_res = a | b;
         ALU_XOR:  alu_res = a ^ b;
         ALU_PASS: alu_res = b;
         ALU_LSL:  alu_res = a << b[SH-1:0];
         ALU_LSR:  alu_res = a >> b[SH-1:0];
         ALU_ADD: begin
            sum     = {1'b0, a} + {1'b0, b};
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_SUB: begin
            // a + ~b + 1: carry-out is set when no borrow occurs (a >= b).
            sum     = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         default:  alu_res = {WIDTH{ALU_UNDEF}};
      endcase
   end

   assign alu_flags = alu_flags_f(alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v);

`ifdef ALU_SEQ_MUL_EN
   logic             mul_start;
   logic             mul_done;
   logic [WIDTH-1:0] mul_prod;

   alu_mul_iter #(
      .WIDTH    (WIDTH),
      .MUL_STEP (MUL_STEP)
   ) u_mul (
      .clk       (clk),
      .reset     (reset),
      .start_i   (mul_start),
      .a_i       (a),
      .b_i       (b),
      .done_o    (mul_done),
      .product_o (mul_prod)
   );
`endif

   // Control FSM
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      flags_d  = flags_q;
`ifdef ALU_SEQ_MUL_EN
      mul_start = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               result_d = alu_res;
               flags_d  = alu_flags;
               state_d  = DONE;
`ifdef ALU_SEQ_MUL_EN
               // MUL leaves the output registers alone until the product lands.
               if (ALUControl == ALU_MUL) begin
                  mul_start = 1'b1;
                  result_d  = result_q;
                  flags_d   = flags_q;
                  state_d   = BUSY;
               end
`endif
            end
         end
`ifdef ALU_SEQ_MUL_EN
         BUSY: begin
            if (mul_done) begin
               result_d = mul_prod;
               flags_d  = alu_flags_f(mul_prod[WIDTH-1], mul_prod == '0, 1'b0, 1'b0);
               state_d  = DONE;
            end
         end
`endif
         DONE: begin
            // Returning to IDLE costs one bubble before the next accept.
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign zero      = flags_q.z;
   assign negative  = flags_q.n;
   assign carry     = flags_q.c;
   assign overflow  = flags_q.v;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq : self-checking bench for alu_seq (WIDTH=64, MUL_STEP=1).
//   Reference model computes results from plain arithmetic on the opcode
//   semantics; latency is counted in falling edges after the accept edge.
// ---------------------------------------------------------------------------
module tb_alu_seq;

   localparam int W     = 64;
   localparam int MS    = 1;
   localparam int STEPS = W / MS;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0] a_r, b_r, result;
   logic [3:0]   op_r;
   logic         zero, negative, carry, overflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(W), .MUL_STEP(MS)) dut (
      .clk        (clk),
      .reset      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a_r),
      .b          (b_r),
      .ALUControl (op_r),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .zero       (zero),
      .negative   (negative),
      .carry      (carry),
      .overflow   (overflow)
   );

   function automatic bit mul_enabled();
`ifdef ALU_SEQ_MUL_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   // Reference model: result plus C/V; N/Z follow from the result.
   function automatic void ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, output logic [W-1:0] r,
                                   output logic c, output logic v);
      logic signed [W+1:0] exact;
      logic signed [W+1:0] trunc;
      c = 1'b0;
      v = 1'b0;
      case (op)
         4'd0: r = a & b;
         4'd1: r = a | b;
         4'd3: r = a ^ b;
         4'd7: r = b;
         4'd4: r = a << (b % W);
         4'd5: r = a >> (b % W);
         4'd2: begin
            r     = a + b;
            c     = (r < a);
            exact = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b});
            trunc = $signed({{2{r[W-1]}}, r});
            v     = (exact != trunc);
         end
         4'd6: begin
            r     = a - b;
            c     = (a >= b);
            exact = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b});
            trunc = $signed({{2{r[W-1]}}, r});
            v     = (exact != trunc);
         end
         4'd8: r = mul_enabled() ? a * b : '1;
         default: r = '1;
      endcase
   endfunction

   function automatic int exp_lat(input logic [3:0] op);
      return (mul_enabled() && op == 4'd8) ? STEPS + 1 : 1;
   endfunction

   // Drives one request, waits for the result, captures it, then pops it.
   task automatic drive_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] r, output logic [3:0] nzcv, output int lat,
                           output bit ready_leak);
      int guard = 0;
      ready_leak = 1'b0;
      @(negedge clk);
      while (!in_ready && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      op_r = op; a_r = a; b_r = b; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a_r = {$urandom, $urandom};
      b_r = {$urandom, $urandom};
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (!out_valid && in_ready) ready_leak = 1'b1;
      end while (!out_valid && lat < 300);
      if (!out_valid) lat = 9999;
      r    = result;
      nzcv = {negative, zero, carry, overflow};
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      checks++;
      if ({out_valid, in_ready} !== 2'b01 || result !== '0) begin
         errors++;
         $display("FAIL reset_state: out_valid=%0b in_ready=%0b result=%h want 0/1/0",
                  out_valid, in_ready, result);
      end
      checks++;
      if ({negative, zero, carry, overflow} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: nzcv=%b want 0000", {negative, zero, carry, overflow});
      end
   endtask

   task automatic check_vector(input string name, input logic [3:0] op,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] want_r, input logic [3:0] want_nzcv);
      logic [W-1:0] r;
      logic [3:0]   f;
      int           lat;
      bit           leak;
      drive_op(op, a, b, r, f, lat, leak);
      checks++;
      if (r !== want_r || f !== want_nzcv) begin
         errors++;
         $display("FAIL %s: result=%h nzcv=%b want %h %b", name, r, f, want_r, want_nzcv);
      end
      checks++;
      if (lat !== exp_lat(op)) begin
         errors++;
         $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat(op));
      end
   endtask

   task automatic test_directed;
      check_vector("add_wrap", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b0110);
      check_vector("sub_ovf", 4'b0110, 64'h8000_0000_0000_0000, 64'd1,
                   64'h7FFF_FFFF_FFFF_FFFF, 4'b0011);
      check_vector("sub_borrow", 4'b0110, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000);
      check_vector("undef_f", 4'b1111, 64'h1234, 64'h5678, '1, 4'b1000);
      check_vector("lsr", 4'b0101, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 4'b0000);
      if (!mul_enabled())
         check_vector("mul_undef", 4'b1000, 64'd7, 64'd9, '1, 4'b1000);
   endtask

   task automatic test_mul;
      logic [W-1:0] r;
      logic [3:0]   f;
      int           lat;
      bit           leak;
      drive_op(4'b1000, 64'd7, 64'd9, r, f, lat, leak);
      checks++;
      if (r !== 64'd63 || f !== 4'b0000) begin
         errors++;
         $display("FAIL mul_7x9: result=%0d nzcv=%b want 63 0000", r, f);
      end
      checks++;
      if (lat !== STEPS + 1 || leak) begin
         errors++;
         $display("FAIL mul_latency: got %0d ready_leak=%0b want %0d 0", lat, leak, STEPS + 1);
      end
   endtask

   task automatic test_random;
      logic [W-1:0] a, b, r, want_r;
      logic [3:0]   op, f;
      logic         c, v;
      int           lat;
      bit           leak;
      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = {$urandom, $urandom};
         b  = (i % 4 == 0) ? a : {$urandom, $urandom};
         if (i % 7 == 0) a = 64'h8000_0000_0000_0000 | {32'd0, $urandom};
         ref_alu(op, a, b, want_r, c, v);
         drive_op(op, a, b, r, f, lat, leak);
         checks++;
         if (r !== want_r || f !== {want_r[W-1], want_r == '0, c, v} || lat !== exp_lat(op)) begin
            errors++;
            $display("FAIL random[%0d] op=%b: result=%h nzcv=%b lat=%0d want %h %b %0d",
                     i, op, r, f, lat, want_r, {want_r[W-1], want_r == '0, c, v}, exp_lat(op));
         end
      end
   endtask

   task automatic test_backpressure;
      int guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      op_r = 4'b0100; a_r = 64'd1; b_r = 64'd65; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      #1;
      // A competing request held during DONE must be ignored.
      op_r = 4'b0010; a_r = 64'd3; b_r = 64'd4;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 64'd2) begin
            errors++;
            $display("FAIL bp_hold[%0d]: out_valid=%0b in_ready=%0b result=%0d want 1 0 2",
                     k, out_valid, in_ready, result);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: in_ready=%0b out_valid=%0b want 1 0", in_ready, out_valid);
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || result !== 64'd7 || carry !== 1'b0) begin
         errors++;
         $display("FAIL bp_next_op: out_valid=%0b result=%0d want 1 7", out_valid, result);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset_abort;
      @(negedge clk);
      op_r = mul_enabled() ? 4'b1000 : 4'b0001;
      a_r = 64'hFF; b_r = 64'h3; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || result !== '0 || zero !== 1'b0) begin
         errors++;
         $display("FAIL abort_in_reset: out_valid=%0b result=%h zero=%0b want 0 0 0",
                  out_valid, result, zero);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_release: in_ready=%0b out_valid=%0b want 1 0", in_ready, out_valid);
      end
      // Well past any MUL latency: no stale result may appear.
      repeat (STEPS + 4) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || result !== '0) begin
         errors++;
         $display("FAIL abort_no_output: out_valid=%0b result=%h want 0 0", out_valid, result);
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      op_r = '0; a_r = '0; b_r = '0;
      repeat (3) @(negedge clk);
      test_reset;
      rst_n = 1'b1;
      test_directed;
      if (mul_enabled()) test_mul;
      test_backpressure;
      test_random;
      test_reset_abort;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
